// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between a data requester (A) and an
// instruction-fetch requester (B), with a watchdog that aborts transactions lacking mem_ack.
//
// state  | meaning
// IDLE   | no transaction outstanding; arbitrate on req_a/req_b
// BUSY_A | A owns the port; waiting for mem_ack or watchdog expiry
// BUSY_B | B owns the port; waiting for mem_ack or watchdog expiry
module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              we_b,
  output logic              done_a,
  output logic              done_b,
  output logic              err_a,
  output logic              err_b,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                last_a_q, last_a_d;
  logic                sel_q, sel_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                done_a_q, done_a_d;
  logic                done_b_q, done_b_d;
  logic                err_a_q, err_a_d;
  logic                err_b_q, err_b_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                grant_a, grant_b;
  logic                busy_done, busy_abort;

  // On a tie the requester that did not win last time gets the port.
  assign grant_a = req_a && (!req_b || !last_a_q);
  assign grant_b = req_b && (!req_a || last_a_q);

  // mem_ack takes priority over the watchdog when both land on the same edge.
  assign busy_done  = mem_ack;
  assign busy_abort = !mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    last_a_d    = last_a_q;
    sel_d       = sel_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    err_a_d     = 1'b0;
    err_b_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_a) begin
          state_d     = BUSY_A;
          last_a_d    = 1'b1;
          sel_d       = 1'b1;
          mem_req_d   = 1'b1;
          mem_addr_d  = addr_a;
          mem_wdata_d = wdata_a;
          mem_we_d    = we_a;
          cnt_d       = '0;
        end else if (grant_b) begin
          state_d     = BUSY_B;
          last_a_d    = 1'b0;
          sel_d       = 1'b0;
          mem_req_d   = 1'b1;
          mem_addr_d  = addr_b;
          mem_wdata_d = wdata_b;
          mem_we_d    = we_b;
          cnt_d       = '0;
        end
      end
      BUSY_A, BUSY_B: begin
        if (busy_done || busy_abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          rdata_d   = busy_done ? mem_rdata : '0;
          done_a_d  = (state_q == BUSY_A);
          done_b_d  = (state_q == BUSY_B);
          err_a_d   = busy_abort && (state_q == BUSY_A);
          err_b_d   = busy_abort && (state_q == BUSY_B);
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_a_q    <= 1'b0;
      sel_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_a_q    <= last_a_d;
      sel_q       <= sel_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
    end
  end

  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign err_a     = err_a_q;
  assign err_b     = err_b_q;
  assign rdata     = rdata_q;
  assign sel       = sel_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge,
// expectations hand-computed from the arbitration and watchdog timing.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, req_b, we_b, mem_ack;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b, mem_rdata;
  logic        done_a, done_b, err_a, err_b, sel, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a),
    .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b),
    .done_a(done_a), .done_b(done_b), .err_a(err_a), .err_b(err_b),
    .rdata(rdata), .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(); cyc();
    rst_n = 1'b1;
    vectors++; if ({done_a, done_b, err_a, err_b, sel, mem_req, mem_we} !== 7'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b expected 0", {done_a, done_b, err_a, err_b, sel, mem_req, mem_we}); end
    vectors++; if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", {rdata, mem_addr, mem_wdata}); end
    req_a = 1'b1; addr_a = 32'h55; wdata_a = 32'h66; we_a = 1'b1;
    cyc();
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h55) begin miscompares++; $display("FAIL reset_pre_grant: got req=%b addr=%h expected 1/55", mem_req, mem_addr); end
    rst_n = 1'b0; cyc(); cyc();
    vectors++; if ({done_a, err_a, sel, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mid_busy: got ctrl=%b addr=%h wdata=%h expected 0", {done_a, err_a, sel, mem_req, mem_we}, mem_addr, mem_wdata); end
    rst_n = 1'b1; req_a = 1'b0; mem_ack = 1'b1;
    cyc();
    vectors++; if (done_a !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_no_done: got done_a=%b mem_req=%b expected 0/0", done_a, mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_single_read();
    req_a = 1'b1; addr_a = 32'h100; we_a = 1'b0; wdata_a = 32'h0;
    cyc();
    vectors++; if (sel !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin miscompares++; $display("FAIL read_grant: got sel=%b req=%b addr=%h we=%b expected 1/1/100/0", sel, mem_req, mem_addr, mem_we); end
    cyc(); cyc();
    vectors++; if (done_a !== 1'b0 || mem_req !== 1'b1) begin miscompares++; $display("FAIL read_wait: got done_a=%b req=%b expected 0/1", done_a, mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc();
    vectors++; if (done_a !== 1'b1 || err_a !== 1'b0 || done_b !== 1'b0 || rdata !== 32'hDEADBEEF || mem_req !== 1'b0) begin miscompares++; $display("FAIL read_done: got done_a=%b err_a=%b done_b=%b rdata=%h req=%b expected 1/0/0/deadbeef/0", done_a, err_a, done_b, rdata, mem_req); end
    mem_ack = 1'b0; req_a = 1'b0;
    cyc();
    vectors++; if (done_a !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL read_pulse: got done_a=%b req=%b expected 0/0", done_a, mem_req); end
  endtask

  task automatic test_fairness();
    logic exp_a;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    req_a = 1'b1; addr_a = 32'hA0; we_a = 1'b0;
    req_b = 1'b1; addr_b = 32'hB0; we_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      cyc();
      vectors++; if (sel !== exp_a || mem_req !== 1'b1 || mem_addr !== (exp_a ? 32'hA0 : 32'hB0)) begin miscompares++; $display("FAIL tie_grant%0d: got sel=%b req=%b addr=%h expected %b/1/%h", i, sel, mem_req, mem_addr, exp_a, exp_a ? 32'hA0 : 32'hB0); end
      mem_ack = 1'b1; mem_rdata = 32'h1000 + i;
      cyc();
      vectors++; if (done_a !== exp_a || done_b !== !exp_a || rdata !== 32'h1000 + i) begin miscompares++; $display("FAIL tie_done%0d: got done_a=%b done_b=%b rdata=%h expected %b/%b/%h", i, done_a, done_b, rdata, exp_a, !exp_a, 32'h1000 + i); end
      mem_ack = 1'b0;
    end
    req_a = 1'b0; req_b = 1'b0;
    cyc();
    vectors++; if (mem_req !== 1'b0 || sel !== 1'b0) begin miscompares++; $display("FAIL tie_idle: got req=%b sel=%b expected 0/0", mem_req, sel); end
  endtask

  task automatic test_timeout();
    int  hi = 0;
    bit  seen = 0;
    req_b = 1'b1; addr_b = 32'h200; we_b = 1'b0; mem_rdata = 32'hFFFF0000;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (mem_req) hi++;
      if (done_b) seen = 1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL timeout_seen: got no done_b expected done_b within 40 cycles"); end
    vectors++; if (hi != 16) begin miscompares++; $display("FAIL timeout_len: got %0d mem_req cycles expected 16", hi); end
    vectors++; if (err_b !== 1'b1 || rdata !== 32'h0 || done_a !== 1'b0 || err_a !== 1'b0) begin miscompares++; $display("FAIL timeout_err: got err_b=%b rdata=%h done_a=%b err_a=%b expected 1/0/0/0", err_b, rdata, done_a, err_a); end
    req_b = 1'b0;
    cyc();
    vectors++; if (done_b !== 1'b0 || err_b !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse: got done_b=%b err_b=%b expected 0/0", done_b, err_b); end
  endtask

  task automatic test_ack_terminal();
    req_b = 1'b1; addr_b = 32'h240;
    cyc();
    for (int i = 0; i < 15; i++) cyc();
    vectors++; if (mem_req !== 1'b1 || done_b !== 1'b0) begin miscompares++; $display("FAIL term_wait: got req=%b done_b=%b expected 1/0", mem_req, done_b); end
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    cyc();
    vectors++; if (done_b !== 1'b1 || err_b !== 1'b0 || rdata !== 32'h12345678) begin miscompares++; $display("FAIL term_ack: got done_b=%b err_b=%b rdata=%h expected 1/0/12345678", done_b, err_b, rdata); end
    mem_ack = 1'b0; req_b = 1'b0;
    cyc();
  endtask

  task automatic test_stability();
    req_a = 1'b1; addr_a = 32'h300; wdata_a = 32'hCAFE; we_a = 1'b1;
    cyc();
    vectors++; if (sel !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hCAFE || mem_we !== 1'b1) begin miscompares++; $display("FAIL stab_grant: got sel=%b addr=%h wdata=%h we=%b expected 1/300/cafe/1", sel, mem_addr, mem_wdata, mem_we); end
    addr_a = 32'h400; wdata_a = 32'h0; we_a = 1'b0; req_a = 1'b0; req_b = 1'b1; addr_b = 32'h500;
    cyc();
    vectors++; if (sel !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hCAFE || mem_we !== 1'b1) begin miscompares++; $display("FAIL stab_hold1: got sel=%b req=%b addr=%h wdata=%h we=%b expected 1/1/300/cafe/1", sel, mem_req, mem_addr, mem_wdata, mem_we); end
    req_a = 1'b1;
    cyc();
    vectors++; if (mem_addr !== 32'h300 || mem_wdata !== 32'hCAFE || sel !== 1'b1) begin miscompares++; $display("FAIL stab_hold2: got addr=%h wdata=%h sel=%b expected 300/cafe/1", mem_addr, mem_wdata, sel); end
    req_b = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5;
    cyc();
    vectors++; if (done_a !== 1'b1 || done_b !== 1'b0 || err_a !== 1'b0 || rdata !== 32'h5) begin miscompares++; $display("FAIL stab_done: got done_a=%b done_b=%b err_a=%b rdata=%h expected 1/0/0/5", done_a, done_b, err_a, rdata); end
    req_a = 1'b0;
    cyc();
    vectors++; if (done_a !== 1'b0 || done_b !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL stab_stray_ack: got done_a=%b done_b=%b req=%b expected 0/0/0", done_a, done_b, mem_req); end
    mem_ack = 1'b0;
    cyc();
    vectors++; if (mem_req !== 1'b0 || done_a !== 1'b0 || sel !== 1'b1 || mem_addr !== 32'h300) begin miscompares++; $display("FAIL stab_idle: got req=%b done_a=%b sel=%b addr=%h expected 0/0/1/300", mem_req, done_a, sel, mem_addr); end
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0; mem_ack = 1'b0;
    addr_a = '0; wdata_a = '0; addr_b = '0; wdata_b = '0; mem_rdata = '0;
    test_reset();
    test_single_read();
    test_fairness();
    test_timeout();
    test_ack_terminal();
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
